fir_seq: RTL and testbench
==========================

FIR_SEQ -- requirements
Module: fir_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  single system clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 coef_start  in  1  request to load all four 8-bit coefficients serially; sampled only in IDLE.
REQ-005 coef_bit  in  1  serial coefficient data, one bit per LOAD cycle.
REQ-006 sample_valid  in  1  a new sample is present on the datapath input; upstream holds the sample stable while this is high.
REQ-007 sample_ready  out  1  the sample is consumed this cycle; transfer occurs when sample_valid and sample_ready are both 1.
REQ-008 mux_control  out  2  tap select driven to both datapath muxes (0 = current sample and c0 … 3 = a3 and c3).
REQ-009 clear_accum  out  1  synchronous clear of the datapath accumulator.
REQ-010 accum_en  out  1  accumulator captures accumulator + product.
REQ-011 shift_en  out  1  coefficient shift chain advances one bit.
REQ-012 shift_in  out  1  serial bit fed to the head of the coefficient chain.
REQ-013 data_en  out  1  delay line advances and output register captures the accumulator.
REQ-014 y_valid  out  1  one-cycle pulse; the datapath y output holds the new result.
REQ-015 coef_ok  out  1  a complete coefficient load has finished since reset.
REQ-016 busy  out  1  the state is not IDLE.

Function
REQ-017 The FSM SHALL have these states: IDLE, LOAD, CLR, MAC, LATCH, OUT.
REQ-018 In IDLE with coef_start=1: go to LOAD and clear the 5-bit bit counter; coef_start has priority over sample_valid.
REQ-019 In LOAD, the block SHALL drive shift_en=1 and shift_in=coef_bit (combinational) for exactly 32 consecutive cycles, then return to IDLE and set coef_ok=1.
REQ-020 The coefficient bit order SHALL be: first bit loaded ends in c3[7], last bit ends in c0[0], giving a plain 32-bit serial shift.
REQ-021 In IDLE with sample_valid=1, coef_start=0 and coef_ok=1: go to CLR.
REQ-022 In IDLE with coef_ok=0, sample_valid SHALL be ignored; sample_ready stays 0 and no datapath strobe is asserted.
REQ-023 CLR SHALL last 1 cycle with clear_accum=1, then go to MAC with the tap counter at 0.
REQ-024 MAC SHALL last 4 cycles with accum_en=1 and mux_control = tap counter (0,1,2,3), then go to LATCH.
REQ-025 LATCH SHALL last 1 cycle with data_en=1, sample_ready=1 and mux_control=0, then go to OUT.
REQ-026 OUT SHALL last 1 cycle with y_valid=1, then go to IDLE.
REQ-027 Timing: if IDLE sees sample_valid at cycle N, then clear_accum is at N+1, accum_en at N+2 to N+5, data_en and sample_ready at N+6, and y_valid at N+7. The minimum sample spacing is 8 cycles.
REQ-028 In every state, outputs not listed for that state SHALL be 0. Apart from shift_in, all outputs SHALL be decoded from registered state and counters.
REQ-029 clear_accum, accum_en, shift_en and data_en SHALL be mutually exclusive in every cycle.
REQ-030 coef_start outside IDLE SHALL be ignored (not queued). sample_valid outside IDLE and LATCH SHALL have no effect.
REQ-031 If sample_valid drops before LATCH, the sequence SHALL still complete. The result is then undefined, and that is an upstream protocol violation.
REQ-032 The bit counter SHALL wrap from 31 to 0 exactly on the LOAD-to-IDLE transition. The tap counter SHALL wrap from 3 to 0 on the MAC-to-LATCH transition.
REQ-033 A reload after coef_ok=1 SHALL be allowed. coef_ok SHALL stay 1 during the reload.

Reset
REQ-034 When reset=0, the block SHALL asynchronously force: state IDLE, both counters 0, coef_ok=0, and all outputs 0 (including busy and y_valid).
REQ-035 Reset asserted during LOAD, MAC or LATCH SHALL abort the sequence with no further strobes. After release the block SHALL wait in IDLE and require a fresh coefficient load.
REQ-036 The first rising clk edge after reset deasserts SHALL evaluate the IDLE transitions normally.

Verification
REQ-037 Load: coef_start for 1 cycle, then coef_bit = 32-bit pattern 0x01020304 MSB first -> shift_en high for exactly 32 cycles, shift_in equals the pattern, then coef_ok=1 and busy=0.
REQ-038 Sample before load: after reset, sample_valid=1 held for 10 cycles with coef_ok=0 -> sample_ready, clear_accum, accum_en and data_en all stay 0.
REQ-039 Single sample: coef_ok=1, sample_valid rises at cycle N -> clear_accum at N+1; mux_control 0,1,2,3 with accum_en at N+2 to N+5; data_en and sample_ready at N+6; y_valid at N+7; IDLE at N+8.
REQ-040 Back-to-back: sample_valid held high across 3 samples -> y_valid pulses at 8-cycle spacing; exactly 3 sample_ready handshakes.
REQ-041 Priority and reset: coef_start=1 and sample_valid=1 in the same IDLE cycle -> LOAD is taken first. Reset=0 pulsed mid-MAC -> all outputs 0 immediately, coef_ok=0, and no y_valid follows.
REQ-042 A bench checker SHALL assert on every cycle that REQ-029 mutual exclusion holds and that sample_ready=1 only in LATCH.

Source files
------------

// File: rtl/fir_seq_if.sv
// Handshake and datapath-strobe bundle between the FIR sequencer and its neighbours.
// master: upstream source plus datapath (drives requests, observes strobes).
// slave:  the fir_seq controller.
interface fir_seq_if;
  logic       coef_start;
  logic       coef_bit;
  logic       sample_valid;
  logic       sample_ready;
  logic [1:0] mux_control;
  logic       clear_accum;
  logic       accum_en;
  logic       shift_en;
  logic       shift_in;
  logic       data_en;
  logic       y_valid;
  logic       coef_ok;
  logic       busy;

  modport master (
    output coef_start, coef_bit, sample_valid,
    input  sample_ready, mux_control, clear_accum, accum_en, shift_en,
           shift_in, data_en, y_valid, coef_ok, busy
  );

  modport slave (
    input  coef_start, coef_bit, sample_valid,
    output sample_ready, mux_control, clear_accum, accum_en, shift_en,
           shift_in, data_en, y_valid, coef_ok, busy
  );
endinterface

// File: rtl/fir_seq.sv
// Sequencer for a 4-tap serial-MAC FIR datapath.
// Loads 32 coefficient bits serially, then per sample runs
// CLR -> MAC x4 -> LATCH -> OUT (8 cycles from IDLE back to IDLE).
// All strobes except shift_in are decoded from registered state/counters.
module fir_seq (
  input  logic     clk,
  input  logic     reset,
  fir_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CLR   = 3'd2;
  localparam logic [2:0] S_MAC   = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  logic [2:0] state;
  logic [4:0] bit_cnt;
  logic [1:0] tap_cnt;
  logic       coef_ok_q;

  // State and counter update; coef_start wins over sample_valid in IDLE,
  // and samples are ignored until a full coefficient load has completed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      tap_cnt   <= '0;
      coef_ok_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.coef_start) begin
            state   <= S_LOAD;
            bit_cnt <= '0;
          end else if (bus.sample_valid && coef_ok_q) begin
            state <= S_CLR;
          end
        end
        S_LOAD: begin
          // 5-bit counter wraps 31 -> 0 on the same edge that leaves LOAD
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            state     <= S_IDLE;
            coef_ok_q <= 1'b1;
          end
        end
        S_CLR: begin
          state   <= S_MAC;
          tap_cnt <= '0;
        end
        S_MAC: begin
          tap_cnt <= tap_cnt + 2'd1;
          if (tap_cnt == 2'd3) state <= S_LATCH;
        end
        S_LATCH: state <= S_OUT;
        S_OUT:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode: one strobe per state, so the datapath enables are exclusive by construction
  assign bus.shift_en     = (state == S_LOAD);
  assign bus.shift_in     = (state == S_LOAD) & bus.coef_bit;
  assign bus.clear_accum  = (state == S_CLR);
  assign bus.accum_en     = (state == S_MAC);
  assign bus.mux_control  = (state == S_MAC) ? tap_cnt : 2'd0;
  assign bus.data_en      = (state == S_LATCH);
  assign bus.sample_ready = (state == S_LATCH);
  assign bus.y_valid      = (state == S_OUT);
  assign bus.busy         = (state != S_IDLE);
  assign bus.coef_ok      = coef_ok_q;

endmodule

// File: tb/tb_fir_seq.sv
// Bench for fir_seq: per-cycle expected output vectors are queued as stimulus
// is driven and compared by a negedge monitor; tasks add scenario checks.
module tb_fir_seq;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fir_seq_if bus ();

  fir_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int ST_IDLE = 0, ST_LOAD = 1, ST_CLR = 2, ST_MAC = 3, ST_LATCH = 4, ST_OUT = 5;

  typedef struct {
    logic [10:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   hs_cnt = 0;
  int   yv_cyc[$];

  // {busy, coef_ok, shift_en, shift_in, clear_accum, accum_en, mux[1:0], data_en, sample_ready, y_valid}
  logic [10:0] obs;
  assign obs = {bus.busy, bus.coef_ok, bus.shift_en, bus.shift_in, bus.clear_accum,
                bus.accum_en, bus.mux_control, bus.data_en, bus.sample_ready, bus.y_valid};

  // Expected output vector for a given state, from the state table of the block
  function automatic logic [10:0] model(int st, logic ok, logic [1:0] tap, logic sin);
    logic [10:0] v;
    v    = '0;
    v[9] = ok;
    case (st)
      ST_LOAD:  begin v[10] = 1'b1; v[8] = 1'b1; v[7] = sin; end
      ST_CLR:   begin v[10] = 1'b1; v[6] = 1'b1; end
      ST_MAC:   begin v[10] = 1'b1; v[5] = 1'b1; v[4:3] = tap; end
      ST_LATCH: begin v[10] = 1'b1; v[2] = 1'b1; v[1] = 1'b1; end
      ST_OUT:   begin v[10] = 1'b1; v[0] = 1'b1; end
      default:  ;
    endcase
    return v;
  endfunction

  task automatic push(int st, logic ok, logic [1:0] tap, logic sin, string tag);
    exp_t e;
    e.v   = model(st, ok, tap, sin);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(logic ok, string tag);
    push(ST_CLR, ok, 2'd0, 1'b0, tag);
    for (int t = 0; t < 4; t++) push(ST_MAC, ok, 2'(t), 1'b0, tag);
    push(ST_LATCH, ok, 2'd0, 1'b0, tag);
    push(ST_OUT, ok, 2'd0, 1'b0, tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor plus per-cycle protocol invariants
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_chk++;
      if (obs !== mon_e.v) begin
        n_fail++;
        $display("FAIL sb_%s cyc=%0d got=%b expected=%b", mon_e.tag, cyc, obs, mon_e.v);
      end
    end
    n_chk++;
    if ($countones({bus.clear_accum, bus.accum_en, bus.shift_en, bus.data_en}) > 1) begin
      n_fail++;
      $display("FAIL strobe_exclusive cyc=%0d got clr/acc/sh/den=%b expected at most one",
               cyc, {bus.clear_accum, bus.accum_en, bus.shift_en, bus.data_en});
    end
    n_chk++;
    if (bus.sample_ready === 1'b1 && !(bus.data_en === 1'b1 && bus.busy === 1'b1 &&
        bus.accum_en === 1'b0 && bus.y_valid === 1'b0)) begin
      n_fail++;
      $display("FAIL ready_only_latch cyc=%0d got vec=%b expected ready only with data_en", cyc, obs);
    end
    if (bus.sample_valid === 1'b1 && bus.sample_ready === 1'b1) hs_cnt++;
    if (bus.y_valid === 1'b1) yv_cyc.push_back(cyc);
  end

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_chk++;
    if (obs !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b expected=%b", obs, 11'd0);
    end
    reset = 1'b1;
    tick();
    n_chk++;
    if (obs !== 11'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle got=%b expected=%b", obs, 11'd0);
    end
  endtask

  task automatic test_sample_before_load();
    int hs0;
    hs0 = hs_cnt;
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 10; i++) push(ST_IDLE, 1'b0, 2'd0, 1'b0, "no_coef");
    for (int i = 0; i < 10; i++) tick();
    bus.sample_valid = 1'b0;
    n_chk++;
    if (hs_cnt !== hs0) begin
      n_fail++;
      $display("FAIL no_coef_handshake got=%0d expected=%0d", hs_cnt - hs0, 0);
    end
  endtask

  task automatic test_load(logic [31:0] pat, logic with_valid, logic ok_before);
    logic [31:0] word;
    word = '0;
    bus.coef_start   = 1'b1;
    bus.sample_valid = with_valid;
    push(ST_IDLE, ok_before, 2'd0, 1'b0, "load_start");
    for (int i = 0; i < 32; i++) push(ST_LOAD, ok_before, 2'd0, pat[31-i], "load");
    push(ST_IDLE, 1'b1, 2'd0, 1'b0, "load_done");
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i == 0) begin
        bus.coef_start   = 1'b0;
        bus.sample_valid = 1'b0;
      end
      bus.coef_bit = pat[31-i];
      #1;
      word = {word[30:0], bus.shift_in};
    end
    tick();
    bus.coef_bit = 1'b0;
    tick();
    n_chk++;
    if (word !== pat) begin
      n_fail++;
      $display("FAIL load_serial_word got=%h expected=%h", word, pat);
    end
  endtask

  task automatic test_single();
    int c0, hs0, ny0;
    c0  = cyc;
    hs0 = hs_cnt;
    ny0 = yv_cyc.size();
    bus.sample_valid = 1'b1;
    push(ST_IDLE, 1'b1, 2'd0, 1'b0, "single");
    push_frame(1'b1, "single");
    push(ST_IDLE, 1'b1, 2'd0, 1'b0, "single_end");
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 7) bus.sample_valid = 1'b0;
    end
    n_chk++;
    if (hs_cnt - hs0 !== 1) begin
      n_fail++;
      $display("FAIL single_handshakes got=%0d expected=%0d", hs_cnt - hs0, 1);
    end
    n_chk++;
    if (yv_cyc.size() - ny0 !== 1 || yv_cyc[yv_cyc.size()-1] !== c0 + 7) begin
      n_fail++;
      $display("FAIL single_yvalid_cycle got=%0d expected=%0d", yv_cyc[yv_cyc.size()-1] - c0, 7);
    end
  endtask

  task automatic test_back_to_back();
    int c0, hs0, ny0;
    c0  = cyc;
    hs0 = hs_cnt;
    ny0 = yv_cyc.size();
    bus.sample_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      push(ST_IDLE, 1'b1, 2'd0, 1'b0, "b2b");
      push_frame(1'b1, "b2b");
    end
    push(ST_IDLE, 1'b1, 2'd0, 1'b0, "b2b_end");
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 23) bus.sample_valid = 1'b0;
    end
    n_chk++;
    if (hs_cnt - hs0 !== 3) begin
      n_fail++;
      $display("FAIL b2b_handshakes got=%0d expected=%0d", hs_cnt - hs0, 3);
    end
    n_chk++;
    if (yv_cyc.size() - ny0 !== 3) begin
      n_fail++;
      $display("FAIL b2b_yvalid_count got=%0d expected=%0d", yv_cyc.size() - ny0, 3);
    end else begin
      for (int s = 0; s < 3; s++) begin
        n_chk++;
        if (yv_cyc[ny0+s] !== c0 + 7 + 8*s) begin
          n_fail++;
          $display("FAIL b2b_yvalid_spacing got=%0d expected=%0d", yv_cyc[ny0+s] - c0, 7 + 8*s);
        end
      end
    end
  endtask

  task automatic test_priority();
    // coef_start and sample_valid together in IDLE: load must win, coef_ok stays 1
    test_load(32'hA5C3_0F96, 1'b1, 1'b1);
    test_single();
  endtask

  task automatic test_reset_mid_mac();
    int ny0, hs0;
    ny0 = yv_cyc.size();
    hs0 = hs_cnt;
    bus.sample_valid = 1'b1;
    push(ST_IDLE, 1'b1, 2'd0, 1'b0, "rst_mac");
    push(ST_CLR, 1'b1, 2'd0, 1'b0, "rst_mac");
    push(ST_MAC, 1'b1, 2'd0, 1'b0, "rst_mac");
    for (int i = 0; i < 3; i++) tick();
    n_chk++;
    if (obs !== model(ST_MAC, 1'b1, 2'd1, 1'b0)) begin
      n_fail++;
      $display("FAIL rst_pre_mac1 got=%b expected=%b", obs, model(ST_MAC, 1'b1, 2'd1, 1'b0));
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if (obs !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_async_outputs got=%b expected=%b", obs, 11'd0);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) push(ST_IDLE, 1'b0, 2'd0, 1'b0, "rst_after");
    for (int i = 0; i < 12; i++) tick();
    bus.sample_valid = 1'b0;
    n_chk++;
    if (yv_cyc.size() !== ny0 || hs_cnt !== hs0) begin
      n_fail++;
      $display("FAIL rst_no_yvalid got y=%0d hs=%0d expected y=0 hs=0", yv_cyc.size() - ny0, hs_cnt - hs0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.coef_start   = 1'b0;
    bus.coef_bit     = 1'b0;
    bus.sample_valid = 1'b0;
    test_reset();
    test_sample_before_load();
    test_load(32'h0102_0304, 1'b0, 1'b0);
    test_single();
    test_back_to_back();
    test_priority();
    test_reset_mid_mac();
    n_chk++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d expected=%0d", exp_q.size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
